// File: rtl/div_sched.sv
// Round-robin front end for one shared iterative radix-2 divider (signed/unsigned), one op in flight.
// Latency: 34 edges accept-to-response for WIDTH=32 (2 edges on divide-by-zero); response held until taken.
module div_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_signed,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_dbz
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic [1:0]       grant;
  logic             accept;
  logic             acc_id;
  logic [WIDTH-1:0] a_q, b_q, dvs, quo, rem;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             sgn, id_q, neg_q, neg_r, dbz;
  logic [CW-1:0]    count;

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Gated by rst_n so no grant is offered while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign acc_id    = req_ready[1];

  assign a_mag   = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag   = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = (b_q == '0) ? FIX : ITER;
      ITER:    if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      sgn        <= 1'b0;
      id_q       <= 1'b0;
      dvs        <= '0;
      quo        <= '0;
      rem        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dbz        <= 1'b0;
      count      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_q      <= '0;
      rsp_r      <= '0;
      rsp_dbz    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q        <= acc_id ? a1 : a0;
          b_q        <= acc_id ? b1 : b0;
          sgn        <= req_signed[acc_id];
          id_q       <= acc_id;
          last_grant <= acc_id;
        end
        SETUP: begin
          rem   <= '0;
          quo   <= a_mag;
          dvs   <= b_mag;
          neg_q <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= sgn & a_q[WIDTH-1];
          dbz   <= (b_q == '0);
          count <= '0;
        end
        ITER: begin
          // trial[WIDTH] set means the subtraction borrowed: restore.
          rem   <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          count <= count + 1'b1;
        end
        FIX: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_dbz   <= dbz;
          if (dbz) begin
            rsp_q <= '1;
            rsp_r <= a_q;
          end else begin
            rsp_q <= neg_q ? -quo : quo;
            rsp_r <= neg_r ? -rem : rem;
          end
        end
        DONE: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: latency, signed/unsigned results, divide-by-zero, arbitration, backpressure, reset.
module tb_div_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_signed;
  logic [31:0] a0, b0, a1, b1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_dbz;
  logic [31:0] rsp_q, rsp_r;

  int n_tests = 0;
  int n_fail  = 0;

  div_sched #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz)
  );

  always #5 clk = ~clk;

  // Present one request at a negedge; returns just after the accepting posedge.
  task automatic issue(input int port, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (port == 0) begin a0 = a; b0 = b; end
    else           begin a1 = a; b1 = b; end
    req_signed[port] = sgn;
    req_valid = 2'b01 << port;
    @(posedge clk);
    #1 req_valid = 2'b00;
  endtask

  // Counts posedges after the accept until rsp_valid is seen at a negedge.
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (edges < 200) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    n_tests++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_q !== 32'h0 ||
        rsp_r !== 32'h0 || rsp_dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b id=%b q=%h r=%h dbz=%b, want all zero",
               req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_priority: req_ready=%b want 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_basic();
    int e;
    issue(0, 1'b1, 32'd100, 32'd7);
    wait_rsp(e);
    n_tests++;
    if (e != 34) begin
      n_fail++;
      $display("FAIL basic_latency: %0d edges want 34", e);
    end
    n_tests++;
    if (rsp_q !== 32'd14 || rsp_r !== 32'd2 || rsp_id !== 1'b0 || rsp_dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: q=%h r=%h id=%b dbz=%b want 0000000e 00000002 0 0", rsp_q, rsp_r, rsp_id, rsp_dbz);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_handshake: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_signed_unsigned();
    int e;
    issue(1, 1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_rsp(e);
    n_tests++;
    if (rsp_q !== 32'hFFFF_FFF2 || rsp_r !== 32'hFFFF_FFFE || rsp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL neg_dividend: q=%h r=%h id=%b want fffffff2 fffffffe 1", rsp_q, rsp_r, rsp_id);
    end
    issue(0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_rsp(e);
    n_tests++;
    if (rsp_q !== 32'hFFFF_FFF2 || rsp_r !== 32'd2) begin
      n_fail++;
      $display("FAIL neg_divisor: q=%h r=%h want fffffff2 00000002", rsp_q, rsp_r);
    end
    issue(0, 1'b0, 32'hFFFF_FFFF, 32'd2);
    wait_rsp(e);
    n_tests++;
    if (rsp_q !== 32'h7FFF_FFFF || rsp_r !== 32'd1) begin
      n_fail++;
      $display("FAIL unsigned: q=%h r=%h want 7fffffff 00000001", rsp_q, rsp_r);
    end
    issue(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_rsp(e);
    n_tests++;
    if (rsp_q !== 32'h8000_0000 || rsp_r !== 32'd0 || rsp_dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_overflow: q=%h r=%h dbz=%b want 80000000 0 0", rsp_q, rsp_r, rsp_dbz);
    end
  endtask

  task automatic test_dbz();
    int e;
    issue(0, 1'b1, 32'h1234_5678, 32'd0);
    wait_rsp(e);
    n_tests++;
    if (e != 2) begin
      n_fail++;
      $display("FAIL dbz_latency: %0d edges want 2", e);
    end
    n_tests++;
    if (rsp_q !== 32'hFFFF_FFFF || rsp_r !== 32'h1234_5678 || rsp_dbz !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: q=%h r=%h dbz=%b want ffffffff 12345678 1", rsp_q, rsp_r, rsp_dbz);
    end
  endtask

  task automatic test_round_robin();
    int e;
    logic [31:0] exp_q, exp_r;
    do_reset();
    a0 = 32'd1000; b0 = 32'd7;
    a1 = 32'hFFFF_FFFF; b1 = 32'd16;
    req_signed = 2'b01;
    req_valid  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(e);
      exp_q = (k % 2 == 0) ? 32'd142 : 32'h0FFF_FFFF;
      exp_r = (k % 2 == 0) ? 32'd6   : 32'd15;
      n_tests++;
      if (e >= 200 || rsp_id !== k[0] || rsp_q !== exp_q || rsp_r !== exp_r) begin
        n_fail++;
        $display("FAIL rr_rsp%0d: id=%b q=%h r=%h want %b %h %h", k, rsp_id, rsp_q, rsp_r, k[0], exp_q, exp_r);
      end
      @(posedge clk);
    end
    req_valid = 2'b00;
    wait_rsp(e);
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    int e;
    rsp_ready = 1'b0;
    issue(1, 1'b1, 32'd100, 32'd7);
    wait_rsp(e);
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_q !== 32'd14 || rsp_r !== 32'd2 || rsp_id !== 1'b1 || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_c%0d: valid=%b q=%h r=%h id=%b ready=%b want 1 0000000e 00000002 1 00",
                 c, rsp_valid, rsp_q, rsp_r, rsp_id, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || !$onehot(req_ready)) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b ready=%b want 0 and one-hot", rsp_valid, req_ready);
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL accept_after_release: ready=%b want 00", req_ready);
    end
    req_valid = 2'b00;
    wait_rsp(e);
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int e;
    issue(1, 1'b0, 32'd500, 32'd3);
    repeat (16) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    a0 = 32'd50; b0 = 32'd5; req_signed = 2'b00;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_outputs: valid=%b ready=%b want 0 00", rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL midreset_priority: ready=%b want 01", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp(e);
    n_tests++;
    if (e != 34 || rsp_id !== 1'b0 || rsp_q !== 32'd10 || rsp_r !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_next: edges=%0d id=%b q=%h r=%h want 34 0 0000000a 0", e, rsp_id, rsp_q, rsp_r);
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; req_signed = 2'b00; rsp_ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_basic();
    test_signed_unsigned();
    test_dbz();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
